gpio_bus_arbiter: RTL and testbench
===================================

// Module: gpio_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one GPIO register-bank slave port between NUM_MASTERS requesters.
//  Typical requesters: Ibex core, pixel-readout sequencer, debug master. Uses the Ibex data-bus
//  protocol (req/gnt, later rvalid). Allows one outstanding transaction at a time.
//  Sits between the masters and the gpio peripheral. A timeout terminates any transaction
//  whose response never arrives, so a hung slave cannot lock up the masters.
// PARAMETERS
//  NUM_MASTERS     2     number of requesters, 2..8
//  ADDR_W          32    address width
//  DATA_W          32    data width; byte enables are DATA_W/8 wide
//  TIMEOUT_CYCLES  16    cycles in WAIT_RESP before error termination, >=2
// PORTS
//  clk        in   1                  clock, all logic on posedge
//  rst        in   1                  asynchronous reset, active-high
//  m_req      in   NUM_MASTERS        per-master request
//  m_we       in   NUM_MASTERS        per-master write enable
//  m_be       in   NUM_MASTERS*DATA_W/8   per-master byte enables, master i at slice i
//  m_addr     in   NUM_MASTERS*ADDR_W     per-master address, master i at slice i
//  m_wdata    in   NUM_MASTERS*DATA_W     per-master write data, master i at slice i
//  m_gnt      out  NUM_MASTERS        per-master grant, one-hot or zero
//  m_rvalid   out  NUM_MASTERS        per-master response valid, one-hot or zero
//  m_err      out  NUM_MASTERS        per-master response error; valid only with m_rvalid
//  m_rdata    out  DATA_W             shared read data, broadcast to all masters
//  s_req      out  1                  slave request
//  s_we       out  1                  slave write enable
//  s_be       out  DATA_W/8           slave byte enables
//  s_addr     out  ADDR_W             slave address
//  s_wdata    out  DATA_W             slave write data
//  s_gnt      in   1                  slave grant
//  s_rvalid   in   1                  slave response valid
//  s_err      in   1                  slave response error
//  s_rdata    in   DATA_W             slave read data
//  timeout    out  1                  one-cycle pulse on timeout termination
//  busy       out  1                  high while a transaction is outstanding (state WAIT_RESP)
// BEHAVIOUR
//  - FSM: IDLE, WAIT_RESP. Registers: state, owner, rr_ptr (next highest-priority master), tmr.
//  - Reset, and while rst is high: state=IDLE, owner=0, rr_ptr=0, tmr=0.
//    All outputs are 0 while rst is high, including s_req and m_gnt.
//  - can_issue = (state==IDLE) || (state==WAIT_RESP && s_rvalid). This allows back-to-back issue
//    in the cycle the previous response returns.
//  - Selection, combinational: sel = first i with m_req[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_MASTERS.
//  - s_req = can_issue & |m_req. s_we/s_be/s_addr/s_wdata are muxed from sel; they are 0 when s_req=0.
//  - m_gnt[sel] = s_req & s_gnt, with zero latency. All other m_gnt bits are 0.
//  - On the handshake (s_req & s_gnt): owner<=sel, rr_ptr<=(sel+1) mod NUM_MASTERS,
//    state<=WAIT_RESP, tmr<=0.
//  - WAIT_RESP, s_rvalid=1: m_rvalid[owner]=1, m_err[owner]=s_err, m_rdata=s_rdata, all
//    combinational pass-through. Next state is WAIT_RESP on a new handshake this cycle, else IDLE.
//  - WAIT_RESP, s_rvalid=0: tmr<=tmr+1. When tmr==TIMEOUT_CYCLES-1 in the same cycle:
//    m_rvalid[owner]=1, m_err[owner]=1, m_rdata=0, timeout=1, state<=IDLE.
//    No new grant is issued in that cycle.
//  - tmr width is $clog2(TIMEOUT_CYCLES); it never wraps because it is cleared on each handshake.
//  - s_rvalid in IDLE (late or stray response) is discarded: no m_rvalid, no state change.
//  - m_rdata is 0 whenever no m_rvalid bit is high.
//  - Requester may drop m_req before being granted; the next arbitration simply skips it.
//    A master's m_req with s_gnt=0 stalls, and rr_ptr does not advance.
//  - rst asserted mid-transaction: the outstanding transaction is abandoned and no response is
//    delivered. The first grant after reset goes to the lowest-index requesting master.
//  - Latency: grant 0 cycles; response = slave latency + 0. With the gpio slave (gnt=req, rvalid
//    one cycle later), one transaction completes per cycle when requests are sustained.
// TESTING
//  - Single master 0 writes 0xA5 to addr 0x008 -> m_gnt[0] same cycle; m_rvalid[0] next cycle, m_err=0.
//  - m_req=2'b11 held, slave gnt=req / rvalid +1 -> grants alternate 0,1,0,1 on consecutive cycles.
//  - Back-to-back: response to m0 and m1 grant occur in the same cycle -> busy stays 1.
//  - Slave never raises rvalid, TIMEOUT_CYCLES=16 -> 16 cycles after grant: m_rvalid=1, m_err=1,
//    m_rdata=0, timeout=1; then IDLE.
//  - Stray s_rvalid in IDLE with m_req=0 -> all m_rvalid stay 0, state unchanged.
//  - rst pulsed in WAIT_RESP, then m_req=2'b11 -> no response for old transaction; master 0 granted first.

Source files
------------

// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle between the requesters, the round-robin arbiter and the shared GPIO slave port.
// Handshake: a request is accepted in the cycle req & gnt are both high; its response is the
// later single-cycle rvalid pulse (err/rdata qualified by rvalid); only one request is in flight.
interface gpio_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS-1:0]        m_we;
  logic [NUM_MASTERS*BE_W-1:0]   m_be;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [NUM_MASTERS-1:0]        m_err;
  logic [DATA_W-1:0]             m_rdata;

  logic              s_req;
  logic              s_we;
  logic [BE_W-1:0]   s_be;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic              s_err;
  logic [DATA_W-1:0] s_rdata;

  // The arbiter is the slave of this bundle: it serves the requesters and fronts the GPIO port.
  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata, s_gnt, s_rvalid, s_err, s_rdata,
    output m_gnt, m_rvalid, m_err, m_rdata, s_req, s_we, s_be, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata, s_gnt, s_rvalid, s_err, s_rdata,
    input  m_gnt, m_rvalid, m_err, m_rdata, s_req, s_we, s_be, s_addr, s_wdata
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO slave port among NUM_MASTERS Ibex-style requesters,
// one outstanding transaction, with a response timeout so a hung slave cannot lock the bus.
module gpio_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  gpio_bus_arbiter_if.slave   bus,
  output logic                timeout,
  output logic                busy,
  output logic                state_dbg
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE = 1'b0, WAIT_RESP = 1'b1} state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] owner, owner_d, rr_ptr, rr_ptr_d, sel;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic             any_req, can_issue, resp, expire, hs;
  int               scan;

  logic                   s_req_d, s_we_d;
  logic [BE_W-1:0]        s_be_d;
  logic [ADDR_W-1:0]      s_addr_d;
  logic [DATA_W-1:0]      s_wdata_d, m_rdata_d;
  logic [NUM_MASTERS-1:0] m_gnt_d, m_rvalid_d, m_err_d;
  logic                   timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      tmr    <= '0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      rr_ptr <= rr_ptr_d;
      tmr    <= tmr_d;
    end
  end

  // Scan from rr_ptr upward (wrapping) and take the first requester found.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    scan    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_MASTERS) scan = scan - NUM_MASTERS;
      if (!any_req && bus.m_req[IDX_W'(scan)]) begin
        any_req = 1'b1;
        sel     = IDX_W'(scan);
      end
    end
  end

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    tmr_d      = tmr;
    s_req_d    = 1'b0;
    s_we_d     = 1'b0;
    s_be_d     = '0;
    s_addr_d   = '0;
    s_wdata_d  = '0;
    m_gnt_d    = '0;
    m_rvalid_d = '0;
    m_err_d    = '0;
    m_rdata_d  = '0;
    timeout_d  = 1'b0;

    resp      = (state == WAIT_RESP) && bus.s_rvalid;
    expire    = (state == WAIT_RESP) && !bus.s_rvalid && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
    can_issue = (state == IDLE) || resp;
    // Reset must silence the slave request even though state already reads IDLE.
    s_req_d   = !rst && can_issue && any_req;
    hs        = s_req_d && bus.s_gnt;

    if (s_req_d) begin
      s_we_d    = bus.m_we[sel];
      s_be_d    = bus.m_be[int'(sel)*BE_W +: BE_W];
      s_addr_d  = bus.m_addr[int'(sel)*ADDR_W +: ADDR_W];
      s_wdata_d = bus.m_wdata[int'(sel)*DATA_W +: DATA_W];
    end

    if (resp) begin
      m_rvalid_d[owner] = 1'b1;
      m_err_d[owner]    = bus.s_err;
      m_rdata_d         = bus.s_rdata;
      state_d           = IDLE;
    end else if (expire) begin
      m_rvalid_d[owner] = 1'b1;
      m_err_d[owner]    = 1'b1;
      timeout_d         = 1'b1;
      state_d           = IDLE;
      tmr_d             = '0;
    end else if (state == WAIT_RESP) begin
      tmr_d = tmr + 1'b1;
    end

    if (hs) begin
      m_gnt_d[sel] = 1'b1;
      owner_d      = sel;
      rr_ptr_d     = (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
      state_d      = WAIT_RESP;
      tmr_d        = '0;
    end
  end

  assign bus.s_req    = s_req_d;
  assign bus.s_we     = s_we_d;
  assign bus.s_be     = s_be_d;
  assign bus.s_addr   = s_addr_d;
  assign bus.s_wdata  = s_wdata_d;
  assign bus.m_gnt    = m_gnt_d;
  assign bus.m_rvalid = m_rvalid_d;
  assign bus.m_err    = m_err_d;
  assign bus.m_rdata  = m_rdata_d;
  assign timeout      = timeout_d;
  assign busy         = (state == WAIT_RESP);
  assign state_dbg    = (state == WAIT_RESP);
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed and randomized checks of gpio_bus_arbiter against a transaction-level reference model.
module tb_gpio_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic timeout, busy, state_dbg;
  always #5 clk = ~clk;

  gpio_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  gpio_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .timeout   (timeout),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- stimulus state ----------------
  logic [N-1:0]  req, we;
  logic [BW-1:0] be_a   [N];
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] wdata_a[N];

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];   // owner of the single in-flight transaction
  int  ptr;               // master with highest priority at next arbitration
  int  waited;            // cycles spent waiting for the in-flight response
  bit  hs_prev;
  int  cur_sel;
  bit  cur_sreq, cur_pend, cur_rsp, cur_to;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    exp_q.delete();
    ptr     = 0;
    waited  = 0;
    hs_prev = 1'b0;
  endtask

  task automatic drive();
    bus.m_req = req;
    bus.m_we  = we;
    for (int i = 0; i < N; i++) begin
      bus.m_be[i*BW +: BW]    = be_a[i];
      bus.m_addr[i*AW +: AW]  = addr_a[i];
      bus.m_wdata[i*DW +: DW] = wdata_a[i];
    end
  endtask

  // Drive, let combinational outputs settle, compare every output against the model.
  task automatic settle(input string tag);
    int own;
    bit any;
    logic [63:0] e_rvalid, e_err, e_rdata, e_gnt;
    drive();
    #1;
    cur_pend = (exp_q.size() != 0);
    own      = cur_pend ? int'(exp_q[0]) : 0;
    any      = 1'b0;
    cur_sel  = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (!any && req[c]) begin
        any     = 1'b1;
        cur_sel = c;
      end
    end
    cur_rsp  = cur_pend && bus.s_rvalid;
    cur_to   = cur_pend && !bus.s_rvalid && (waited == TO - 1);
    cur_sreq = !rst && (!cur_pend || cur_rsp) && any;
    e_gnt    = (cur_sreq && bus.s_gnt) ? (64'd1 << cur_sel) : 64'd0;
    e_rvalid = (cur_rsp || cur_to) ? (64'd1 << own) : 64'd0;
    e_err    = cur_rsp ? (64'(bus.s_err) << own) : (cur_to ? (64'd1 << own) : 64'd0);
    e_rdata  = cur_rsp ? 64'(bus.s_rdata) : 64'd0;
    chk({tag, ".s_req"},    bus.s_req,    cur_sreq);
    chk({tag, ".s_we"},     bus.s_we,     cur_sreq ? we[cur_sel] : 1'b0);
    chk({tag, ".s_be"},     bus.s_be,     cur_sreq ? be_a[cur_sel] : '0);
    chk({tag, ".s_addr"},   bus.s_addr,   cur_sreq ? addr_a[cur_sel] : '0);
    chk({tag, ".s_wdata"},  bus.s_wdata,  cur_sreq ? wdata_a[cur_sel] : '0);
    chk({tag, ".m_gnt"},    bus.m_gnt,    e_gnt);
    chk({tag, ".m_rvalid"}, bus.m_rvalid, e_rvalid);
    chk({tag, ".m_err"},    bus.m_err,    e_err);
    chk({tag, ".m_rdata"},  bus.m_rdata,  e_rdata);
    chk({tag, ".timeout"},  timeout,      cur_to);
    chk({tag, ".busy"},     busy,         cur_pend);
    chk({tag, ".state"},    state_dbg,    cur_pend);
  endtask

  // Clock edge, then advance the model with the inputs that were applied this cycle.
  task automatic advance();
    bit hs;
    @(posedge clk);
    #1;
    if (rst) begin
      reset_model();
    end else begin
      hs = cur_sreq && bus.s_gnt;
      if (cur_pend) begin
        if (cur_rsp || cur_to) void'(exp_q.pop_front());
        else waited++;
      end
      if (hs) begin
        exp_q.push_back(8'(cur_sel));
        ptr    = (cur_sel + 1) % N;
        waited = 0;
      end
      hs_prev = hs;
    end
    @(negedge clk);
  endtask

  // gpio-like slave: always grants, answers one cycle after each accepted request.
  task automatic gpio_slave();
    bus.s_gnt    = 1'b1;
    bus.s_rvalid = hs_prev;
    bus.s_err    = 1'b0;
    bus.s_rdata  = hs_prev ? $urandom : '0;
  endtask

  task automatic idle_inputs();
    req = '0;
    we  = '0;
    for (int i = 0; i < N; i++) begin
      be_a[i]    = '0;
      addr_a[i]  = '0;
      wdata_a[i] = '0;
    end
    bus.s_gnt    = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_err    = 1'b0;
    bus.s_rdata  = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0] alt_exp[6];
    idle_inputs();
    rst = 1'b1;
    reset_model();
    drive();
    @(negedge clk);

    // Reset holds every output low, even with requests and a granting slave.
    req = 3'b111;
    bus.s_gnt = 1'b1;
    settle("reset");
    chk("reset.m_gnt_zero", bus.m_gnt, '0);
    advance();
    rst = 1'b0;
    idle_inputs();
    settle("post_reset");
    advance();

    // Master 0 writes 0xA5 to 0x008.
    req[0] = 1'b1; we[0] = 1'b1; be_a[0] = 4'hF; addr_a[0] = 32'h008; wdata_a[0] = 32'hA5;
    gpio_slave();
    settle("wr_m0");
    chk("wr_m0.gnt", bus.m_gnt, 3'b001);
    chk("wr_m0.addr", bus.s_addr, 32'h008);
    chk("wr_m0.wdata", bus.s_wdata, 32'hA5);
    advance();
    req = '0;
    gpio_slave();
    settle("wr_m0_resp");
    chk("wr_m0_resp.rvalid", bus.m_rvalid, 3'b001);
    chk("wr_m0_resp.err", bus.m_err, 3'b000);
    advance();

    // Masters 0 and 1 held: grants alternate, back-to-back issue keeps busy high.
    alt_exp = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    req = 3'b011;
    addr_a[1] = 32'h010;
    for (int c = 0; c < 6; c++) begin
      gpio_slave();
      settle("alt");
      chk("alt.gnt_seq", bus.m_gnt, alt_exp[c]);
      if (c > 0) begin
        chk("alt.busy", busy, 1'b1);
        chk("alt.rvalid_prev", bus.m_rvalid, alt_exp[c-1]);
      end
      advance();
    end
    req = '0;
    gpio_slave();
    settle("alt_drain");
    advance();

    // Slave grants master 2 but never responds: timeout after TO waiting cycles.
    req = 3'b100;
    addr_a[2] = 32'h020;
    bus.s_gnt = 1'b1; bus.s_rvalid = 1'b0;
    settle("to_grant");
    chk("to_grant.gnt", bus.m_gnt, 3'b100);
    advance();
    req = '0;
    bus.s_gnt = 1'b0; bus.s_rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= TO; c++) begin
      settle("to_wait");
      if (c < TO) begin
        chk("to_wait.rvalid", bus.m_rvalid, 3'b000);
        chk("to_wait.busy", busy, 1'b1);
      end else begin
        chk("to_fire.rvalid", bus.m_rvalid, 3'b100);
        chk("to_fire.err", bus.m_err, 3'b100);
        chk("to_fire.rdata", bus.m_rdata, 32'h0);
        chk("to_fire.pulse", timeout, 1'b1);
      end
      advance();
    end
    settle("to_after");
    chk("to_after.busy", busy, 1'b0);
    chk("to_after.pulse", timeout, 1'b0);
    advance();

    // Stray response while idle is discarded.
    bus.s_rvalid = 1'b1; bus.s_err = 1'b1; bus.s_rdata = 32'h1234_5678;
    settle("stray");
    chk("stray.rvalid", bus.m_rvalid, 3'b000);
    chk("stray.rdata", bus.m_rdata, 32'h0);
    advance();
    bus.s_rvalid = 1'b0; bus.s_err = 1'b0;
    settle("stray_after");
    chk("stray_after.busy", busy, 1'b0);
    advance();

    // Reset during an outstanding transaction, then contention restarts at master 0.
    req = 3'b001; bus.s_gnt = 1'b1;
    settle("rst_grant");
    advance();
    req = 3'b000; bus.s_gnt = 1'b0;
    settle("rst_wait");
    chk("rst_wait.busy", busy, 1'b1);
    rst = 1'b1;
    reset_model();
    bus.s_rvalid = 1'b1;
    settle("rst_mid");
    chk("rst_mid.busy", busy, 1'b0);
    advance();
    rst = 1'b0;
    settle("rst_late_resp");
    chk("rst_late_resp.rvalid", bus.m_rvalid, 3'b000);
    advance();
    bus.s_rvalid = 1'b0;
    req = 3'b011; bus.s_gnt = 1'b1;
    settle("rst_first");
    chk("rst_first.gnt", bus.m_gnt, 3'b001);
    advance();

    // Randomized traffic with a sometimes-stalling, sometimes-silent slave.
    for (int c = 0; c < 500; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      we  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        be_a[i]    = BW'($urandom);
        addr_a[i]  = $urandom;
        wdata_a[i] = $urandom;
      end
      bus.s_gnt    = ($urandom_range(0, 3) != 0);
      bus.s_rvalid = ($urandom_range(0, 5) == 0);
      bus.s_err    = 1'($urandom);
      bus.s_rdata  = $urandom;
      settle("rand");
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
